// File: rtl/ssd_pkg.sv
// Shared constants and blanking helper for the seven-segment scanner.
package ssd_pkg;

  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  // Bit i set when digit i and all digits above it are zero with no dp.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] disp,
    input logic [MAX_DIGITS-1:0]         dp,
    input int                            n
  );
    logic keep;
    lz_mask = '0;
    keep = 1'b1;
    for (int i = MAX_DIGITS-1; i > 0; i--) begin
      if (i < n) begin
        if (disp[i*DIGIT_W +: DIGIT_W] != '0 || dp[i])
          keep = 1'b0;
        lz_mask[i] = keep;
      end
    end
  endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Refresh prescaler: one-cycle tick every REFRESH_DIV clocks.
module ssd_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV-1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd_scanner.sv
// Multiplexed common-anode digit scanner with leading-zero blanking
// and frame-synchronous load of the displayed value.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic                    busy,
  output logic [3:0]              bcd,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS-1);
  localparam int VW = DIGIT_W*NUM_DIGITS;

  logic                  tick;
  logic                  boundary;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         stage_q, stage_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] sdp_q, sdp_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic                  busy_q, busy_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dpn_q, dpn_d;
  logic                  fd_q, fd_d;
  logic [MAX_DIGITS-1:0] mask;
  logic [3:0]            nib;
  logic                  blank;

  ssd_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign boundary = tick && (idx_q == LAST);

  always_comb begin
    idx_d   = idx_q;
    stage_d = stage_q;
    sdp_d   = sdp_q;
    disp_d  = disp_q;
    ddp_d   = ddp_q;
    busy_d  = busy_q;
    an_d    = an_q;
    bcd_d   = bcd_q;
    dpn_d   = dpn_q;
    fd_d    = boundary;

    if (busy_q) begin
      if (boundary) begin
        disp_d = stage_q;
        ddp_d  = sdp_q;
        busy_d = 1'b0;
      end
    end else if (load) begin
      stage_d = value;
      sdp_d   = dp_in;
      busy_d  = 1'b1;
    end

    if (tick)
      idx_d = boundary ? '0 : idx_q + IW'(1);

    // Use the post-commit register so a new frame starts with new data.
    mask  = lz_mask(32'(disp_d), 8'(ddp_d), NUM_DIGITS);
    nib   = disp_d[idx_d*DIGIT_W +: DIGIT_W];
    blank = blank_lz && mask[idx_d];

    if (tick) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      bcd_d = blank ? BCD_BLANK : nib;
      dpn_d = blank | ~ddp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= LAST;
      stage_q <= '0;
      sdp_q   <= '0;
      disp_q  <= '0;
      ddp_q   <= '0;
      busy_q  <= 1'b0;
      an_q    <= '1;
      bcd_q   <= BCD_BLANK;
      dpn_q   <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      stage_q <= stage_d;
      sdp_q   <= sdp_d;
      disp_q  <= disp_d;
      ddp_q   <= ddp_d;
      busy_q  <= busy_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      dpn_q   <= dpn_d;
      fd_q    <= fd_d;
    end
  end

  assign busy       = busy_q;
  assign an         = an_q;
  assign bcd        = bcd_q;
  assign dp_n       = dpn_q;
  assign frame_done = fd_q;

endmodule
